// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between the E/M and M/W pipeline
// registers. It issues ready-handshake data-memory requests, stalls the front
// of the pipe while an access is outstanding, aborts accesses that wait too
// long, and holds the M/W pipeline register.
//
// Ports
//   clk, reset                : rising-edge clock, async active-low reset
//   RegWriteM..PCPlus4M       : M-stage control and datapath values
//   mem_req/we/addr/wdata     : memory request (combinational)
//   mem_ready, mem_rdata      : memory completion and read data
//   StallM                    : freeze PC, F/D, D/E, E/M (combinational)
//   RegWriteW..PCPlus4W       : registered W-stage values
//   BusErr                    : registered one-cycle pulse on abort
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        BusErr
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             hold_we;
  logic [31:0]      hold_addr;
  logic [31:0]      hold_wdata;

  logic access;
  logic in_idle;
  logic in_wait;
  logic cur_we;
  logic timeout_hit;
  logic complete;
  logic stall;
  logic rd_done;

  // Request/stall decode; mem_* and StallM are forced low while in reset so a
  // pending request disappears asynchronously.
  always_comb begin
    access      = MemWriteM | (ResultSrcM == 2'b01);
    in_idle     = (state == S_IDLE);
    in_wait     = (state == S_WAIT);
    cur_we      = in_wait ? hold_we : MemWriteM;
    timeout_hit = in_wait & ~mem_ready & (wait_cnt == CNT_LAST);
    complete    = (in_idle & access & mem_ready) | (in_wait & mem_ready);
    stall       = (in_idle & access & ~mem_ready) |
                  (in_wait & ~mem_ready & ~timeout_hit);
    rd_done     = complete & ~cur_we;

    mem_req   = reset & ((in_idle & access) | in_wait);
    mem_we    = mem_req & cur_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_addr  = in_wait ? hold_addr  : ALUResultM;
      mem_wdata = in_wait ? hold_wdata : WriteDataM;
    end
    StallM = reset & stall;
  end

  // Access FSM, wait counter and request holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      BusErr     <= 1'b0;
    end else begin
      BusErr <= timeout_hit;
      case (state)
        S_IDLE: begin
          if (access && !mem_ready) begin
            state      <= S_WAIT;
            wait_cnt   <= '0;
            hold_we    <= MemWriteM;
            hold_addr  <= ALUResultM;
            hold_wdata <= WriteDataM;
          end
        end
        S_WAIT: begin
          if (mem_ready || timeout_hit) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= CNT_W'(wait_cnt + 1'b1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // M/W pipeline register: bubble on stall or abort, otherwise advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else if (stall || timeout_hit) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      if (rd_done) begin
        ReadDataW <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl. The stimulus task
// issues one M-stage instruction at a time with a planned memory latency,
// pushes the expected per-instruction outcome, and a monitor checks the DUT
// cycle by cycle and on each retirement (StallM low).
module tb_mem_stage_ctrl;

  localparam int unsigned T = 4;

  logic        clk;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        BusErr;

  mem_stage_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        access;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic        abort;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Architectural W-stage state as the reference model sees it.
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_alu   = '0;
  logic [31:0] m_pc4   = '0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic drive_nop();
    RegWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    RdM        = '0;
    PCPlus4M   = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
  endtask

  // Issue one instruction; n = cycles mem_ready stays low before it rises
  // (n > T means the memory never answers in time).
  task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] rdata, input int n);
    exp_t e;
    e.access = mw | (rs == 2'b01);
    e.we     = mw;
    e.addr   = alu;
    e.wdata  = wd;
    if (!e.access) begin
      e.stalls = 0;
      e.abort  = 1'b0;
    end else if (n <= int'(T)) begin
      e.stalls = n;
      e.abort  = 1'b0;
    end else begin
      e.stalls = int'(T);
      e.abort  = 1'b1;
    end
    if (e.abort) begin
      e.rw = 1'b0;
      e.rs = 2'b00;
    end else begin
      e.rw   = rw;
      e.rs   = rs;
      m_rd   = rd;
      m_alu  = alu;
      m_pc4  = pc4;
      if (e.access && !e.we) m_rdata = rdata;
    end
    e.rd    = m_rd;
    e.alu   = m_alu;
    e.pc4   = m_pc4;
    e.rdata = m_rdata;
    q.push_back(e);
    for (int k = 0; k <= e.stalls; k++) begin
      RegWriteM  = rw;
      ResultSrcM = rs;
      MemWriteM  = mw;
      ALUResultM = alu;
      WriteDataM = wd;
      RdM        = rd;
      PCPlus4M   = pc4;
      mem_ready  = e.access ? (k == n) : 1'($urandom);
      mem_rdata  = (e.access && k == n) ? rdata : $urandom;
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: per-cycle request/stall checks, W-stage check on retirement.
  initial begin : monitor
    int   k;
    exp_t e;
    k = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || q.size() == 0) begin
        k = 0;
      end else begin
        e = q[0];
        chk("stall", 32'(StallM), 32'(k < e.stalls));
        chk("req", 32'(mem_req), 32'(e.access));
        if (e.access) begin
          chk("we", 32'(mem_we), 32'(e.we));
          chk("addr", mem_addr, e.addr);
          chk("wdata", mem_wdata, e.wdata);
        end
        if (k > 0) begin
          chk("bubble_rw", 32'(RegWriteW), 32'(0));
          chk("bubble_rs", 32'(ResultSrcW), 32'(0));
          chk("bubble_buserr", 32'(BusErr), 32'(0));
        end
        if (!StallM) begin
          @(posedge clk);
          #1;
          chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
          chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
          chk("RdW", 32'(RdW), 32'(e.rd));
          chk("ALUResultW", ALUResultW, e.alu);
          chk("ReadDataW", ReadDataW, e.rdata);
          chk("PCPlus4W", PCPlus4W, e.pc4);
          chk("BusErr", 32'(BusErr), 32'(e.abort));
          void'(q.pop_front());
          k = 0;
        end else begin
          k++;
          if (k > int'(T) + 3) begin
            total++;
            bad++;
            $display("FAIL stall_bound: StallM still high after %0d cycles", k);
            void'(q.pop_front());
            k = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    logic [1:0] rs;
    logic       mw;
    int         r;
    int         n;
    reset = 1'b0;
    drive_nop();
    #12;
    // Outputs in reset, including request gating with a load presented.
    ResultSrcM = 2'b01;
    ALUResultM = 32'h100;
    #1;
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_stall", 32'(StallM), 32'(0));
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rw", 32'(RegWriteW), 32'(0));
    chk("rst_rdata", ReadDataW, 32'h0);
    chk("rst_buserr", 32'(BusErr), 32'(0));
    drive_nop();
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted while a load is waiting.
    @(posedge clk);
    #2;
    RegWriteM  = 1'b1;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h300;
    RdM        = 5'd9;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("wait_req", 32'(mem_req), 32'(1));
    chk("wait_stall", 32'(StallM), 32'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'(0));
    chk("midrst_stall", 32'(StallM), 32'(0));
    chk("midrst_rw", 32'(RegWriteW), 32'(0));
    chk("midrst_buserr", 32'(BusErr), 32'(0));
    drive_nop();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("idle_req", 32'(mem_req), 32'(0));
    chk("idle_stall", 32'(StallM), 32'(0));
    chk("idle_buserr", 32'(BusErr), 32'(0));

    mon_en = 1'b1;
    // Zero-wait load.
    issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd5, 32'h1004, 32'hDEADBEEF, 0);
    // Store with three wait cycles.
    issue(1'b0, 2'b00, 1'b1, 32'h200, 32'h1234, 5'd0, 32'h1008, 32'h0, 3);
    // Load that times out, then an ALU op proceeds.
    issue(1'b1, 2'b01, 1'b0, 32'h400, 32'h0, 5'd6, 32'h100C, 32'h55AA55AA, 10);
    // Back-to-back ALU op, zero-wait load, 1-wait store.
    issue(1'b1, 2'b00, 1'b0, 32'h7, 32'h0, 5'd3, 32'h1010, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h500, 32'h0, 5'd4, 32'h1014, 32'hCAFEF00D, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h504, 32'h9999, 5'd0, 32'h1018, 32'h0, 1);
    // Ready on the last allowed wait cycle completes instead of aborting.
    issue(1'b1, 2'b01, 1'b0, 32'h600, 32'h0, 5'd7, 32'h101C, 32'h13572468, int'(T));
    // Load+store together behaves as a write and still forwards RegWrite.
    issue(1'b1, 2'b01, 1'b1, 32'h700, 32'hABCD, 5'd8, 32'h1020, 32'h11111111, 2);

    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom_range(0, 3));
      mw = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      if (r < 6)      n = 0;
      else if (r < 9) n = $urandom_range(1, T);
      else            n = $urandom_range(T + 1, T + 3);
      issue(1'($urandom), rs, mw, $urandom, $urandom, 5'($urandom), $urandom,
            $urandom, n);
    end

    drive_nop();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d instructions never retired", q.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the pipelined RISC-V core. It sits between the E/M pipeline register and the M/W pipeline register, so it consumes RegWriteM, ResultSrcM and MemWriteM together with the M-stage datapath values. It drives a ready-based data-memory handshake, stalls the pipeline while an access is outstanding, aborts accesses that exceed a timeout, and registers the M→W stage outputs itself.

## Interface
- TIMEOUT, 16: maximum wait cycles for mem_ready before abort; legal range 1–255.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- RegWriteM  input  1  register write enable from the E/M stage
- ResultSrcM  input  2  result select; 2'b01 = load
- MemWriteM  input  1  store enable
- ALUResultM  input  32  effective address / ALU result
- WriteDataM  input  32  store data
- RdM  input  5  destination register
- PCPlus4M  input  32  link value
- mem_req  output  1  memory request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  word address (ALUResultM)
- mem_wdata  output  32  store data
- mem_ready  input  1  memory completes the request this cycle
- mem_rdata  input  32  read data, valid when mem_ready=1
- StallM  output  1  freeze PC, F/D, D/E and E/M registers
- RegWriteW, ResultSrcW[1:0], RdW[4:0], ALUResultW[32], ReadDataW[32], PCPlus4W[32]  output  registered W-stage values
- BusErr  output  1  one-cycle pulse when an access is aborted

## Operation
- access = MemWriteM | (ResultSrcM == 2'b01). If both are set, the access is treated as a write, and RegWriteW is still forwarded.
- FSM states:
  - IDLE: if access, mem_req=1 combinationally, with mem_we/addr/wdata taken directly from the M inputs.
    - If mem_ready=1 in the same cycle, the access completes with zero wait and the state stays IDLE.
    - Otherwise go to WAIT and latch addr, wdata and we into internal holding registers.
  - WAIT: mem_req=1, with mem_we/addr/wdata driven from the holding registers. Outputs are stable until completion.
    - mem_ready=1: complete and return to IDLE.
    - Wait counter reaches TIMEOUT: abort, return to IDLE, pulse BusErr.
- StallM = access in IDLE with mem_ready=0, or WAIT with neither mem_ready=1 nor timeout. Computed combinationally.
- Wait counter:
  - 8 bits, cleared on entry to WAIT, incremented each WAIT cycle without ready.
  - Abort fires on the cycle the counter equals TIMEOUT-1 with no ready, so at most TIMEOUT WAIT cycles occur.
- M/W register update on each clk edge:
  - Completing access or non-access instruction: load RegWriteW←RegWriteM, ResultSrcW←ResultSrcM, RdW←RdM, ALUResultW←ALUResultM, PCPlus4W←PCPlus4M. ReadDataW←mem_rdata on a completing read; otherwise ReadDataW holds its value.
  - Stall cycle: insert a bubble by setting RegWriteW←0 and ResultSrcW←2'b00. Other W fields hold.
  - Abort: bubble (RegWriteW←0), and the faulting instruction does not write back.
- BusErr=1 only on the abort cycle edge; registered, 0 otherwise.
- mem_req is never asserted when access=0 in IDLE.

## Timing
- All outputs reset to 0 when reset=0, asynchronously: mem_req, mem_we, mem_addr, mem_wdata, StallM, all W fields, BusErr, counter. The FSM resets to IDLE.
- Zero-wait memory: one instruction per cycle, no stall, W outputs valid one edge after the M inputs.
- N cycles with mem_ready low (N < TIMEOUT): StallM is high for exactly N cycles. The W update occurs at the edge of the ready cycle.
- StallM deasserts in the same cycle mem_ready rises, so the upstream stage advances at that edge.
- Reset asserted in WAIT: mem_req drops immediately (asynchronously) and no completion or BusErr is produced. The pending request is lost.
- mem_ready with mem_req=0 is ignored.

## Test plan
- Reset: hold reset=0 mid-WAIT → mem_req=0, StallM=0, RegWriteW=0, BusErr=0 immediately; FSM idle after release.
- Zero-wait load: ResultSrcM=01, ALUResultM=0x100, mem_ready=1, mem_rdata=0xDEADBEEF, RdM=5 → StallM=0; next edge ReadDataW=0xDEADBEEF, RdW=5, RegWriteW=1.
- 3-wait store: MemWriteM=1, addr 0x200, WriteDataM=0x1234, ready high on 4th cycle → StallM=1 for 3 cycles, mem_addr/wdata stable at 0x200/0x1234, RegWriteW=0 during stall; completion edge clean.
- Timeout: TIMEOUT=4, load with mem_ready stuck 0 → 4 WAIT cycles, then BusErr one-cycle pulse, RegWriteW=0, StallM drops, next instruction proceeds.
- Back-to-back: ALU op (RegWriteM=1, ALUResultM=7), then a zero-wait load, then a 1-wait store → W fields update per cycle, single stall cycle only for the store, mem_req never high during the ALU op.
